bn_stat_accum: RTL and testbench
================================

Name: bn_stat_accum

Overview:
- Streaming statistics block for the batch-norm datapath: accumulates LANES unsigned pixels per beat over 2^BEATS_LOG2 beats, then emits the group mean and, optionally, the group variance.
- Generalises the fixed 16-lane combinational averager with parametrised lanes, width and depth, multi-beat accumulation, variance mode, a flush, and valid/ready handshakes on both sides.
- Sits between the line buffer and the batch-norm scale/shift stage.

Parameters:
DATA_W, 8, width of one unsigned element
LANES_LOG2, 4, log2 of lanes per beat (LANES = 2^LANES_LOG2)
BEATS_LOG2, 2, log2 of beats per group
SHIFT (derived, localparam), LANES_LOG2+BEATS_LOG2, divide shift

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  beat valid
in_ready  output  1  block accepts beat
in_data  input  DATA_W*LANES  packed lanes; lane i = in_data[i*DATA_W +: DATA_W]
mode  input  1  0 = mean only, 1 = mean + variance; sampled on the first beat of a group
flush  input  1  synchronous abort of the current group
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_mean  output  DATA_W  floor(sum / 2^SHIFT)
out_var  output  2*DATA_W  variance result; 0 when mode = 0
grp_cnt  output  16  completed groups handed off, wraps at 2^16

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst_n = 0:
  - state = IDLE; all accumulators, beat counter and grp_cnt = 0.
  - out_valid = 0; out_mean = 0; out_var = 0; in_ready = 0 during reset, 1 after release.
- Beat handshake: a beat is accepted on a rising edge with in_valid & in_ready.
- States:
  - IDLE: in_ready = 1. An accepted beat loads sum = lane_sum and sq = lane_sqsum, latches mode, sets beat_cnt = 1, and goes to ACCUM. If BEATS_LOG2 = 0, it goes straight to FINAL.
  - ACCUM: in_ready = 1. Each accepted beat adds into the accumulators and increments beat_cnt. The beat with beat_cnt = 2^BEATS_LOG2 - 1 is the last; it goes to FINAL.
  - FINAL: in_ready = 0, one cycle.
    - Register out_mean = sum >> SHIFT.
    - If the latched mode = 1: out_var = (sq >> SHIFT) - out_mean^2; otherwise out_var = 0.
    - Set out_valid = 1 and go to DONE.
  - DONE: in_ready = 0. out_valid, out_mean and out_var hold stable until out_valid & out_ready. On that edge: out_valid = 0, grp_cnt increments, state = IDLE.
- Latency: last beat accepted at edge E0 → out_valid = 1 after E1. If out_ready is held high, the result is consumed at E2, and the first beat of the next group is accepted no earlier than E3.
- Arithmetic and widths:
  - lane_sum: DATA_W+LANES_LOG2 bits; lane_sqsum: 2*DATA_W+LANES_LOG2 bits; both combinational adder trees.
  - sum: DATA_W+SHIFT bits; sq: 2*DATA_W+SHIFT bits; no overflow is possible.
  - Division truncates (floor).
  - floor(E[x^2]) >= floor(E[x])^2, so the variance subtraction never underflows.
- mode is ignored on non-first beats.
- flush:
  - In IDLE or ACCUM: clears the accumulators and beat_cnt, returns to IDLE, and discards any beat presented in the same cycle (flush has priority).
  - In FINAL or DONE: ignored; the pending result is still delivered.
- out_ready while out_valid = 0 has no effect.
- Reset asserted mid-group or mid-DONE: the result is lost, outputs clear immediately (asynchronous), and grp_cnt = 0.
- grp_cnt wraps from 0xFFFF to 0x0000.

Test Plan (defaults: 16 lanes, 4 beats, 64 elements, SHIFT = 6):
- Ramp: 4 beats, every lane = 255, mode = 1 → out_mean = 255, out_var = 0; out_valid rises one cycle after the edge accepting the last beat.
- Alternating lanes 0/255 across all beats, mode = 1 → sum = 8160, out_mean = 127; sq = 2080800, sq>>6 = 32512; out_var = 32512 - 16129 = 16383.
- Same data with mode = 0 on beat 0 and mode = 1 on beats 1-3 → out_mean = 127, out_var = 0.
- Backpressure: out_ready held low for 5 cycles after out_valid → outputs stable, in_ready = 0 and in_valid ignored; out_ready = 1 → one handshake, grp_cnt increments by 1, in_ready = 1 on the next cycle.
- Flush after 2 beats of all-200 lanes, asserted together with a valid beat, then a clean group of all-10 → that beat is dropped, out_mean = 10, out_var = 0, grp_cnt increments once.
- rst_n pulsed low during ACCUM and again during DONE → out_valid = 0, grp_cnt = 0, state = IDLE immediately; the next full group of all-7 gives out_mean = 7.

Source files
------------

// File: rtl/bn_stat_accum.sv
// Streaming group statistics: accumulates LANES unsigned elements per beat over
// 2^BEATS_LOG2 beats, then emits floor mean and (optionally) floor variance.
module bn_stat_accum #(
  parameter int DATA_W     = 8,
  parameter int LANES_LOG2 = 4,
  parameter int BEATS_LOG2 = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W*(1<<LANES_LOG2)-1:0]   in_data,
  input  logic                                mode,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_W-1:0]                   out_mean,
  output logic [2*DATA_W-1:0]                 out_var,
  output logic [15:0]                         grp_cnt
);

  // state  | meaning
  // IDLE   | waiting for the first beat of a group
  // ACCUM  | adding beats until the last one of the group
  // FINAL  | one cycle: compute and register mean / variance
  // DONE   | result held until downstream handshake

  localparam int LANES  = 1 << LANES_LOG2;
  localparam int SHIFT  = LANES_LOG2 + BEATS_LOG2;
  localparam int LSUM_W = DATA_W + LANES_LOG2;
  localparam int LSQ_W  = 2*DATA_W + LANES_LOG2;
  localparam int SUM_W  = DATA_W + SHIFT;
  localparam int SQ_W   = 2*DATA_W + SHIFT;
  localparam int VAR_W  = 2*DATA_W;
  localparam int CNT_W  = BEATS_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((1 << BEATS_LOG2) - 1);
  localparam bit SINGLE_BEAT = (BEATS_LOG2 == 0);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [SQ_W-1:0]     sq_q, sq_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                mode_q, mode_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   mean_q, mean_d;
  logic [VAR_W-1:0]    var_q, var_d;
  logic [15:0]         grp_cnt_q, grp_cnt_d;

  logic [LSUM_W-1:0]   lane_sum;
  logic [LSQ_W-1:0]    lane_sqsum;
  logic [DATA_W-1:0]   mean_next;
  logic [VAR_W-1:0]    mean_ext;
  logic [VAR_W-1:0]    mean_sq;
  logic [VAR_W-1:0]    sq_mean;
  logic                accept;

  always_comb begin
    lane_sum   = '0;
    lane_sqsum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum   = lane_sum + LSUM_W'(in_data[i*DATA_W +: DATA_W]);
      lane_sqsum = lane_sqsum + LSQ_W'(in_data[i*DATA_W +: DATA_W]) *
                                LSQ_W'(in_data[i*DATA_W +: DATA_W]);
    end
  end

  // floor(E[x^2]) >= floor(E[x])^2, so the subtraction cannot wrap
  assign mean_next = DATA_W'(sum_q >> SHIFT);
  assign mean_ext  = {{DATA_W{1'b0}}, mean_next};
  assign mean_sq   = mean_ext * mean_ext;
  assign sq_mean   = VAR_W'(sq_q >> SHIFT);

  // gated by rst_n so the block advertises nothing while held in reset
  assign in_ready = rst_n & ((state_q == S_IDLE) || (state_q == S_ACCUM));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    sq_d        = sq_q;
    beat_cnt_d  = beat_cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    mean_d      = mean_q;
    var_d       = var_q;
    grp_cnt_d   = grp_cnt_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (flush) begin
          sum_d      = '0;
          sq_d       = '0;
          beat_cnt_d = '0;
          state_d    = S_IDLE;
        end else if (accept) begin
          if (state_q == S_IDLE) begin
            sum_d      = SUM_W'(lane_sum);
            sq_d       = SQ_W'(lane_sqsum);
            mode_d     = mode;
            beat_cnt_d = CNT_W'(1);
            state_d    = SINGLE_BEAT ? S_FINAL : S_ACCUM;
          end else begin
            sum_d      = sum_q + SUM_W'(lane_sum);
            sq_d       = sq_q + SQ_W'(lane_sqsum);
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (beat_cnt_q == LAST_BEAT) state_d = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        mean_d      = mean_next;
        var_d       = mode_q ? (sq_mean - mean_sq) : '0;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          grp_cnt_d   = grp_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      sq_q        <= '0;
      beat_cnt_q  <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      mean_q      <= '0;
      var_q       <= '0;
      grp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      sq_q        <= sq_d;
      beat_cnt_q  <= beat_cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      mean_q      <= mean_d;
      var_q       <= var_d;
      grp_cnt_q   <= grp_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mean  = mean_q;
  assign out_var   = var_q;
  assign grp_cnt   = grp_cnt_q;

endmodule

// File: tb/tb_bn_stat_accum.sv
// Bench for bn_stat_accum: directed and random groups checked against a
// plain-arithmetic mean/variance model.
module tb_bn_stat_accum;

  localparam int DW = 8;
  localparam int LANES = 16;
  localparam int NB = 4;
  localparam int NELEM = LANES * NB;
  localparam int W = DW * LANES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          mode = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_mean;
  logic [2*DW-1:0] out_var;
  logic [15:0]   grp_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_grp = 16'd0;

  logic [W-1:0] grp_data [NB];
  logic         grp_mode [NB];

  bn_stat_accum #(.DATA_W(DW), .LANES_LOG2(4), .BEATS_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_mean(out_mean), .out_var(out_var),
    .grp_cnt(grp_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*DW +: DW] = DW'(v);
    return d;
  endfunction

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] d;
    for (int l = 0; l < LANES; l++) begin
      case ($urandom_range(0, 3))
        0: d[l*DW +: DW] = 8'd0;
        1: d[l*DW +: DW] = 8'd255;
        default: d[l*DW +: DW] = DW'($urandom_range(0, 255));
      endcase
    end
    return d;
  endfunction

  // reference: mean = floor(S/N), var = floor(Q/N) - mean^2 over all N elements
  task automatic model(output int unsigned m, output int unsigned v);
    longint unsigned s = 0, q = 0, e;
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < LANES; l++) begin
        e = longint'(grp_data[b][l*DW +: DW]);
        s += e;
        q += e * e;
      end
    m = int'(s / NELEM);
    v = grp_mode[0] ? int'(q / NELEM) - m * m : 0;
  endtask

  task automatic feed(input int n);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      check("in_ready_beat", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = grp_data[b];
      mode     = grp_mode[b];
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    mode     = 1'b0;
  endtask

  task automatic run_group(input string tag, input int bp);
    int unsigned em, ev;
    model(em, ev);
    feed(NB);
    check({tag, "_final_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_final_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_mean"}, 32'(out_mean), em);
    check({tag, "_var"}, 32'(out_var), ev);
    for (int c = 0; c < bp; c++) begin
      in_valid = 1'b1;
      in_data  = rand_beat();
      @(negedge clk);
      check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_bp_mean"}, 32'(out_mean), em);
      check({tag, "_bp_var"}, 32'(out_var), ev);
      check({tag, "_bp_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_bp_grp"}, 32'(grp_cnt), 32'(exp_grp));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_grp   = exp_grp + 16'd1;
    check({tag, "_consumed"}, 32'(out_valid), 32'd0);
    check({tag, "_grp"}, 32'(grp_cnt), 32'(exp_grp));
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int unsigned em, ev;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mean", 32'(out_mean), 32'd0);
    check("rst_var", 32'(out_var), 32'd0);
    check("rst_grp", 32'(grp_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // all 255, mode 1
    for (int b = 0; b < NB; b++) begin grp_data[b] = fill(255); grp_mode[b] = 1'b1; end
    run_group("ramp", 0);

    // alternating 0/255 across lanes
    for (int b = 0; b < NB; b++) begin
      for (int l = 0; l < LANES; l++) grp_data[b][l*DW +: DW] = (l % 2 == 1) ? 8'd255 : 8'd0;
      grp_mode[b] = 1'b1;
    end
    model(em, ev);
    check("alt_model_mean", em, 32'd127);
    check("alt_model_var", ev, 32'd16383);
    run_group("alt", 0);

    // mode sampled on beat 0 only
    grp_mode[0] = 1'b0;
    run_group("alt_mode0", 0);

    // backpressure with in_valid presented during DONE
    for (int b = 0; b < NB; b++) grp_mode[b] = 1'b1;
    run_group("bp", 5);

    // flush together with a valid beat after two accepted beats
    for (int b = 0; b < NB; b++) begin grp_data[b] = fill(200); grp_mode[b] = 1'b1; end
    feed(2);
    in_valid = 1'b1;
    in_data  = fill(200);
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    for (int b = 0; b < NB; b++) grp_data[b] = fill(10);
    run_group("after_flush", 0);

    // random groups
    for (int g = 0; g < 8; g++) begin
      for (int b = 0; b < NB; b++) begin
        grp_data[b] = rand_beat();
        grp_mode[b] = 1'($urandom_range(0, 1));
      end
      run_group($sformatf("rand%0d", g), int'($urandom_range(0, 3)));
    end

    // reset during ACCUM
    for (int b = 0; b < NB; b++) begin grp_data[b] = fill(50); grp_mode[b] = 1'b1; end
    feed(2);
    #2 rst_n = 1'b0;
    #1;
    check("rstacc_valid", 32'(out_valid), 32'd0);
    check("rstacc_grp", 32'(grp_cnt), 32'd0);
    check("rstacc_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_grp = 16'd0;

    // reset during DONE
    for (int b = 0; b < NB; b++) grp_data[b] = fill(30);
    feed(NB);
    @(negedge clk);
    check("rstdone_pre_valid", 32'(out_valid), 32'd1);
    check("rstdone_pre_mean", 32'(out_mean), 32'd30);
    #2 rst_n = 1'b0;
    #1;
    check("rstdone_valid", 32'(out_valid), 32'd0);
    check("rstdone_mean", 32'(out_mean), 32'd0);
    check("rstdone_var", 32'(out_var), 32'd0);
    check("rstdone_grp", 32'(grp_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstdone_ready", 32'(in_ready), 32'd1);

    for (int b = 0; b < NB; b++) grp_data[b] = fill(7);
    run_group("post_rst", 0);
    check("post_rst_grp_one", 32'(grp_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
